// File: rtl/i2s_tx_frame_ctrl.sv
// I2S transmit frame sequencer: slot counter, WS/SD generation and double-buffered L/R sample fetch.
// Optional: define I2S_TX_REPEAT_ON_UNDERRUN_EN to repeat the last sample on underrun instead of sending silence.
module i2s_tx_frame_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 17,
  parameter int CNT_WIDTH    = 8,
  localparam int FRAME       = 2 * SLOT_BITS,
  localparam int POS_W       = $clog2(FRAME)
) (
  input  logic                    serial_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mute,
  input  logic                    left_valid,
  input  logic [SAMPLE_WIDTH-1:0] left_data,
  output logic                    left_ready,
  input  logic                    right_valid,
  input  logic [SAMPLE_WIDTH-1:0] right_data,
  output logic                    right_ready,
  input  logic                    underrun_clr,
  output logic                    word_select,
  output logic                    sound_bit_out,
  output logic [POS_W-1:0]        frame_pos,
  output logic                    frame_start,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    underrun_count
);

  localparam logic [POS_W-1:0]     LAST_POS = POS_W'(FRAME - 1);
  localparam logic [POS_W-1:0]     SLOT_POS = POS_W'(SLOT_BITS);
  localparam logic [POS_W-1:0]     SW_POS   = POS_W'(SAMPLE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  localparam logic REPEAT_ON_UNDERRUN = 1'b1;
`else
  localparam logic REPEAT_ON_UNDERRUN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic                    left_full, right_full;
  logic [SAMPLE_WIDTH-1:0] left_hold, right_hold;
  logic [SAMPLE_WIDTH-1:0] left_cur, right_cur;

  logic                    at_last, load_edge, left_cap, right_cap, any_underrun;
  logic [SAMPLE_WIDTH-1:0] left_next, right_next, slot_sample, shifted;
  logic [POS_W-1:0]        pos_next, slot_q;
  logic                    run_next, ws_next, sout_next;

  assign left_ready   = !left_full;
  assign right_ready  = !right_full;
  assign at_last      = (frame_pos == LAST_POS);
  assign load_edge    = enable && ((state == IDLE) || at_last);
  assign left_cap     = left_valid && !left_full;
  assign right_cap    = right_valid && !right_full;
  assign any_underrun = !left_full || !right_full;

  // Samples for the upcoming frame are chosen from the hold state before the edge;
  // a capture on the load edge itself only fills the hold for the following frame.
  always_comb begin
    left_next  = left_cur;
    right_next = right_cur;
    if (load_edge) begin
      if (mute)                    left_next = '0;
      else if (left_full)          left_next = left_hold;
      else if (!REPEAT_ON_UNDERRUN) left_next = '0;
      if (mute)                    right_next = '0;
      else if (right_full)         right_next = right_hold;
      else if (!REPEAT_ON_UNDERRUN) right_next = '0;
    end
  end

  // Outputs are registered from the new position, so the sample MSB lands one clock after WS changes.
  always_comb begin
    run_next = (state == RUN);
    pos_next = frame_pos;
    if (load_edge) begin
      run_next = 1'b1;
      pos_next = '0;
    end else if (state == RUN) begin
      if (at_last) run_next = 1'b0;
      else         pos_next = frame_pos + 1'b1;
    end
    ws_next     = run_next && (pos_next >= SLOT_POS);
    slot_q      = (pos_next >= SLOT_POS) ? (pos_next - SLOT_POS) : pos_next;
    slot_sample = ws_next ? right_next : left_next;
    shifted     = slot_sample << (slot_q - 1'b1);
    sout_next   = run_next && (slot_q != '0) && (slot_q <= SW_POS) && shifted[SAMPLE_WIDTH-1];
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      frame_pos      <= LAST_POS;
      word_select    <= 1'b0;
      sound_bit_out  <= 1'b0;
      frame_start    <= 1'b0;
      busy           <= 1'b0;
      underrun_count <= '0;
      left_full      <= 1'b0;
      right_full     <= 1'b0;
      left_hold      <= '0;
      right_hold     <= '0;
      left_cur       <= '0;
      right_cur      <= '0;
    end else begin
      state         <= run_next ? RUN : IDLE;
      frame_pos     <= pos_next;
      word_select   <= ws_next;
      sound_bit_out <= sout_next;
      frame_start   <= run_next && (pos_next == '0);
      busy          <= run_next;
      left_cur      <= left_next;
      right_cur     <= right_next;

      if (left_cap) begin
        left_hold <= left_data;
        left_full <= 1'b1;
      end else if (load_edge) begin
        left_full <= 1'b0;
      end

      if (right_cap) begin
        right_hold <= right_data;
        right_full <= 1'b1;
      end else if (load_edge) begin
        right_full <= 1'b0;
      end

      if (underrun_clr)
        underrun_count <= '0;
      else if (load_edge && any_underrun && (underrun_count != CNT_MAX))
        underrun_count <= underrun_count + 1'b1;
    end
  end

endmodule

// File: doc/i2s_tx_frame_ctrl.md
Name: i2s_tx_frame_ctrl

Overview:
- Frame sequencer and sample scheduler for the I2S transmit path.
- Owns the slot counter, word select and serial data bit.
- Fetches one left and one right sample per frame from two upstream producers over valid/ready handshakes, double-buffered through per-channel holding registers.
- Handles start/stop on frame boundaries, mute, and underrun accounting.

Parameters:
- SAMPLE_WIDTH, 16: bits per audio sample.
- SLOT_BITS, 17: serial clocks per channel slot; must be >= SAMPLE_WIDTH+1. FRAME = 2*SLOT_BITS = 34.
- CNT_WIDTH, 8: width of the saturating underrun counter.

Ports:
- serial_clk  in  1  bit clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; evaluated only at frame-wrap decision points.
- mute  in  1  when high at a load edge, both current samples are loaded as 0; holding registers are still consumed.
- left_valid  in  1  left sample offered.
- left_data  in  SAMPLE_WIDTH  left sample, two's complement.
- left_ready  out  1  left holding register empty.
- right_valid  in  1  right sample offered.
- right_data  in  SAMPLE_WIDTH  right sample.
- right_ready  out  1  right holding register empty.
- underrun_clr  in  1  synchronous clear of underrun_count.
- word_select  out  1  I2S WS; 0 = left, 1 = right.
- sound_bit_out  out  1  I2S serial data, MSB first.
- frame_pos  out  clog2(FRAME)  current slot position, 0..FRAME-1.
- frame_start  out  1  high for the cycle in which frame_pos==0 while running.
- busy  out  1  state==RUN.
- underrun_count  out  CNT_WIDTH  frames with at least one channel underrun; saturates.

Behaviour:
- Reset values (asynchronous, on reset low):
  - state=IDLE, frame_pos=FRAME-1.
  - word_select=0, sound_bit_out=0, frame_start=0, busy=0, underrun_count=0.
  - Both holding registers empty, so left_ready=right_ready=1.
  - Current samples = 0.
  - Reset mid-frame aborts the frame immediately; no partial state survives.
- Holding registers:
  - ready = !full.
  - valid && ready at an edge captures data and sets full.
  - Capture is independent of state, so producers can preload during IDLE.
- Load edge: the edge on which frame_pos goes FRAME-1 -> 0. This is the IDLE->RUN start edge or a RUN wrap with enable=1. Per channel, using hold state before the edge:
  - Full: current <= hold (or 0 if mute), and full is cleared, so ready rises the following cycle.
  - Empty: underrun; current <= 0.
  - A capture on the same edge fills the hold for the next frame; it does not rescue this frame.
- underrun_count:
  - +1 per load edge with any underrun; both channels underrunning still counts +1.
  - Saturates at 2^CNT_WIDTH-1.
  - underrun_clr wins over a simultaneous increment; the result is 0.
- FSM:
  - IDLE: frame_pos parked at FRAME-1; word_select=0, sound_bit_out=0. If enable=1, the next edge is a load edge: frame_pos=0, state moves to RUN.
  - RUN: frame_pos increments by 1 each edge. At frame_pos==FRAME-1: if enable=1, wrap (load edge); else go to IDLE, frame_pos stays at FRAME-1, and nothing is consumed.
  - Deasserting enable mid-frame always completes the current frame.
- Outputs in RUN (registered; a function of the new frame_pos p):
  - word_select = (p >= SLOT_BITS).
  - With q = p mod SLOT_BITS: sound_bit_out = cur[SAMPLE_WIDTH-q] for 1 <= q <= SAMPLE_WIDTH, else 0.
  - This gives the I2S one-bit delay: MSB one cycle after the WS change.
  - cur is the left sample in the left slot and the right sample in the right slot.
  - frame_start = (p==0).

Optional Feature:
- Macro: I2S_TX_REPEAT_ON_UNDERRUN_EN.
- Defined: an underrunning channel keeps its previous current sample (the last sample repeats). underrun_count behaviour is unchanged. mute still forces 0.
- Undefined: an underrunning channel loads 0 (silence).

Test Plan:
- Preload L=16'hA5A5, R=16'h5A5A, then raise enable -> next edge frame_pos=0, frame_start=1, ws=0, sout=0. Positions 1..16 serialize 1010_0101_1010_0101. pos17: ws=1, sout=0. pos18..33 serialize 5A5A. left_ready/right_ready=1 one cycle after the start edge.
- Supply left only for frame 2 -> frame 2 right slot all 0. underrun_count 0->1. left data correct. With the feature defined, right repeats 5A5A instead.
- enable=0 at frame_pos=10 -> frame runs to pos 33, then busy=0, frame_pos holds 33, ws=0, sout=0 thereafter. Queued holds remain full (ready=0).
- Hold empty; left_valid with 16'h1234 exactly on the load edge -> that frame's left slot=0, count+1. The next frame's left slot serializes 1234.
- Run 300 frames with no data -> underrun_count=255. Pulse underrun_clr on a load edge that also underruns -> count=0.
- Assert reset at frame_pos=20 mid-right-slot -> immediately ws=0, sout=0, busy=0, ready=1, count=0. After release with enable=1 the frame restarts cleanly at pos 0.
